// File: rtl/writeback_unit_pkg.sv
// Shared rv32i writeback definitions: widths, load funct3 encodings, FSM states.
package writeback_unit_pkg;
  localparam int DATA_WIDTH     = 32;
  localparam int REG_ADDR_WIDTH = 5;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [0:0] {
    WB_IDLE      = 1'b0,
    WB_WAIT_LOAD = 1'b1
  } wb_state_e;
endpackage

// File: rtl/writeback_unit_load_formatter.sv
// Combinational load data formatter: selects byte/halfword by offset and extends.
module load_formatter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]            funct3,
  input  logic [1:0]            addr_lo,
  input  logic [DATA_WIDTH-1:0] word,
  output logic [DATA_WIDTH-1:0] data
);
  import writeback_unit_pkg::*;

  logic [7:0]  b;
  logic [15:0] h;

  assign b = word[{addr_lo, 3'b000} +: 8];
  assign h = word[{addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    data = word;
    unique case (funct3)
      F3_LB:   data = {{(DATA_WIDTH-8){b[7]}}, b};
      F3_LBU:  data = {{(DATA_WIDTH-8){1'b0}}, b};
      F3_LH:   data = {{(DATA_WIDTH-16){h[15]}}, h};
      F3_LHU:  data = {{(DATA_WIDTH-16){1'b0}}, h};
      default: data = word;  // LW and reserved encodings pass the full word
    endcase
  end
endmodule

// File: rtl/writeback_unit.sv
// Register-file write-port initiator: 1-cycle ALU commit, load sequencing, decode stall.
// Optional: define WB_BYPASS_EN for bypass outputs in place of the in-flight stall term.
module writeback_unit #(
  parameter int DATA_WIDTH     = writeback_unit_pkg::DATA_WIDTH,
  parameter int REG_ADDR_WIDTH = writeback_unit_pkg::REG_ADDR_WIDTH,
  parameter int LOAD_TIMEOUT   = 255
) (
  input  logic                      CLK,
  input  logic                      RSTn,
  input  logic                      ex_valid,
  output logic                      ex_ready,
  input  logic                      ex_is_load,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
  input  logic [DATA_WIDTH-1:0]     ex_data,
  input  logic [2:0]                ex_funct3,
  input  logic [1:0]                ex_addr_lo,
  input  logic                      mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]     mem_rsp_data,
  input  logic [REG_ADDR_WIDTH-1:0] dec_rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] dec_rs2_addr,
  output logic                      hazard_stall,
  output logic                      rf_write_enable,
  output logic [REG_ADDR_WIDTH-1:0] rf_write_addr,
  output logic [DATA_WIDTH-1:0]     rf_write_data,
  output logic                      load_timeout_err
`ifdef WB_BYPASS_EN
  ,
  output logic                      byp_rs1_hit,
  output logic                      byp_rs2_hit,
  output logic [DATA_WIDTH-1:0]     byp_data
`endif
);
  import writeback_unit_pkg::*;

  localparam logic [7:0] TO_LAST = 8'(LOAD_TIMEOUT - 1);

  wb_state_e                 state_q, state_d;
  logic                      pend_q, pend_d;
  logic [REG_ADDR_WIDTH-1:0] pend_rd_q, pend_rd_d;
  logic [2:0]                f3_q, f3_d;
  logic [1:0]                alo_q, alo_d;
  logic [7:0]                cnt_q, cnt_d;
  logic                      we_q, we_d;
  logic [REG_ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic                      err_q, err_d;
  logic [DATA_WIDTH-1:0]     load_data;

  load_formatter #(.DATA_WIDTH(DATA_WIDTH)) u_fmt (
    .funct3  (f3_q),
    .addr_lo (alo_q),
    .word    (mem_rsp_data),
    .data    (load_data)
  );

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q   <= WB_IDLE;
      pend_q    <= 1'b0;
      pend_rd_q <= '0;
      f3_q      <= '0;
      alo_q     <= '0;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      pend_rd_q <= pend_rd_d;
      f3_q      <= f3_d;
      alo_q     <= alo_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    pend_rd_d = pend_rd_q;
    f3_d      = f3_q;
    alo_d     = alo_q;
    cnt_d     = cnt_q;
    we_d      = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    err_d     = 1'b0;
    ex_ready  = 1'b0;
    unique case (state_q)
      WB_IDLE: begin
        ex_ready = 1'b1;
        if (ex_valid && ex_is_load) begin
          pend_d    = 1'b1;
          pend_rd_d = ex_rd;
          f3_d      = ex_funct3;
          alo_d     = ex_addr_lo;
          cnt_d     = '0;
          state_d   = WB_WAIT_LOAD;
        end else if (ex_valid) begin
          we_d    = (ex_rd != '0);
          waddr_d = ex_rd;
          wdata_d = ex_data;
        end
      end
      WB_WAIT_LOAD: begin
        cnt_d = cnt_q + 8'd1;
        // A response on the last allowed cycle still completes the load.
        if (mem_rsp_valid) begin
          we_d    = (pend_rd_q != '0);
          waddr_d = pend_rd_q;
          wdata_d = load_data;
          pend_d  = 1'b0;
          state_d = WB_IDLE;
        end else if (cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          pend_d  = 1'b0;
          state_d = WB_IDLE;
        end
      end
      default: state_d = WB_IDLE;
    endcase
  end

  assign rf_write_enable  = we_q;
  assign rf_write_addr    = waddr_q;
  assign rf_write_data    = wdata_q;
  assign load_timeout_err = err_q;

  logic load_hit, wr_hit1, wr_hit2;
  assign load_hit = pend_q && (pend_rd_q != '0) &&
                    ((dec_rs1_addr == pend_rd_q) || (dec_rs2_addr == pend_rd_q));
  assign wr_hit1  = we_q && (waddr_q != '0) && (waddr_q == dec_rs1_addr);
  assign wr_hit2  = we_q && (waddr_q != '0) && (waddr_q == dec_rs2_addr);

`ifdef WB_BYPASS_EN
  assign byp_rs1_hit  = wr_hit1;
  assign byp_rs2_hit  = wr_hit2;
  assign byp_data     = wdata_q;
  assign hazard_stall = load_hit;
`else
  // The register file commits at the end of this cycle, so decode would read stale data.
  assign hazard_stall = load_hit || wr_hit1 || wr_hit2;
`endif
endmodule
